// File: rtl/laser_host.sv
// Host-side driver for the two-circle LASER core: loads a point pattern, streams it, waits for DONE, scores coverage.
// Define LASER_HOST_SCORE_EN to build the SCORE state and distance logic; otherwise cover_cnt is tied to zero.
module laser_host #(
`ifdef LASER_HOST_SCORE_EN
  parameter int RADIUS_SQ = 16,
`endif
  parameter int NPTS      = 40,
  parameter int TIMEOUT   = 4096
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load_we,
  input  logic [5:0] load_addr,
  input  logic [3:0] load_x,
  input  logic [3:0] load_y,
  input  logic       start,
  output logic       laser_rst,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic       busy,
  output logic       res_valid,
  output logic [5:0] cover_cnt,
  output logic [3:0] c1x,
  output logic [3:0] c1y,
  output logic [3:0] c2x,
  output logic [3:0] c2y,
  output logic       timeout,
  output logic       proto_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RSTP   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_SCORE  = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    LAST     = 6'(NPTS - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [2:0]    state, state_n;
  logic [5:0]    idx, idx_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          to_n;
  logic          start_ok;
  logic [3:0]    mem_x [NPTS];
  logic [3:0]    mem_y [NPTS];

  assign start_ok = start && (state == S_IDLE);

  // Pattern memory is deliberately not reset so a mid-run reset keeps the loaded pattern.
  always_ff @(posedge CLK) begin
    if (load_we && (state == S_IDLE) && (load_addr < 6'(NPTS))) begin
      mem_x[load_addr] <= load_x;
      mem_y[load_addr] <= load_y;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tmr_n   = tmr;
    to_n    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_n = S_RSTP;
      S_RSTP:   state_n = S_GAP;
      S_GAP: begin
        state_n = S_STREAM;
        idx_n   = 6'd0;
      end
      S_STREAM: begin
        if (idx == LAST) begin
          state_n = S_WAIT;
          tmr_n   = TMR_LOAD;
        end else begin
          idx_n = idx + 6'd1;
        end
      end
      S_WAIT: begin
        if (DONE) begin
`ifdef LASER_HOST_SCORE_EN
          state_n = S_SCORE;
          idx_n   = 6'd0;
`else
          state_n = S_REPORT;
`endif
        end else if (tmr == '0) begin
          state_n = S_REPORT;
          to_n    = 1'b1;
        end else begin
          tmr_n = tmr - TMR_ONE;
        end
      end
`ifdef LASER_HOST_SCORE_EN
      S_SCORE: begin
        if (idx == LAST) state_n = S_REPORT;
        else             idx_n   = idx + 6'd1;
      end
`endif
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      idx       <= 6'd0;
      tmr       <= '0;
      laser_rst <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      timeout   <= 1'b0;
      X         <= 4'd0;
      Y         <= 4'd0;
      c1x       <= 4'd0;
      c1y       <= 4'd0;
      c2x       <= 4'd0;
      c2y       <= 4'd0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tmr       <= tmr_n;
      laser_rst <= (state_n == S_RSTP);
      busy      <= (state_n != S_IDLE);
      res_valid <= (state_n == S_REPORT);
      timeout   <= (state_n == S_REPORT) && to_n;
      X         <= (state_n == S_STREAM) ? mem_x[idx_n] : 4'd0;
      Y         <= (state_n == S_STREAM) ? mem_y[idx_n] : 4'd0;
      if ((state == S_WAIT) && DONE) begin
        c1x <= C1X;
        c1y <= C1Y;
        c2x <= C2X;
        c2y <= C2Y;
      end
      if (DONE && (state != S_WAIT)) proto_err <= 1'b1;
      else if (start_ok)             proto_err <= 1'b0;
    end
  end

`ifdef LASER_HOST_SCORE_EN
  logic [5:0] acc, acc_n;
  logic       hit;

  // Squared distance is kept to 8 bits, matching the core's own arithmetic.
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [7:0] dx, dy, sq;
    dx = {4'd0, (px >= cx) ? (px - cx) : (cx - px)};
    dy = {4'd0, (py >= cy) ? (py - cy) : (cy - py)};
    sq = dx * dx + dy * dy;
    return sq <= 8'(RADIUS_SQ);
  endfunction

  assign hit   = in_circle(mem_x[idx], mem_y[idx], c1x, c1y) ||
                 in_circle(mem_x[idx], mem_y[idx], c2x, c2y);
  assign acc_n = (state == S_SCORE) ? acc + {5'd0, hit} : acc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc       <= 6'd0;
      cover_cnt <= 6'd0;
    end else begin
      if (start_ok) acc <= 6'd0;
      else          acc <= acc_n;
      if (state_n == S_REPORT) cover_cnt <= to_n ? 6'd0 : acc_n;
    end
  end
`else
  assign cover_cnt = 6'd0;
`endif

endmodule
